// File: rtl/id_stage_pkg.sv
// Shared decode constants and types for the instruction-decode stage.
// Holds RV32I opcode/funct codes, zero/enable constants, the operand
// select encodings and the decoder result struct. XLEN and RF_DEPTH are
// module parameters, so nothing here depends on them.
package id_stage_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 codes that need individual treatment
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic [4:0]  ZERO_REG      = 5'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic        READ_ENABLE   = 1'b1;
  localparam logic        READ_DISABLE  = 1'b0;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_IMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR, OP2_ZERO} op2_sel_e;

  // Decoder result; imm is 32 bits and sign-extended to XLEN by the stage.
  typedef struct packed {
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] imm;
    logic        rs1_read;
    logic        rs2_read;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        wen;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/id_stage_if.sv
// Issue/output bus of the decode stage.
// Handshake: an instruction on inst_i/instaddr_i is offered while
// in_valid_i=1 and is consumed on a rising clk edge where in_valid_i=1 and
// in_ready_o=1. Downstream, the registered bundle (valid_o ... illegal_o) is
// taken by EX on every edge where ex_ready_i=1; while ex_ready_i=0 it holds.
// master: upstream/downstream environment view. slave: id_stage view.
interface id_stage_if #(parameter int XLEN = 32);
  logic [31:0]     inst_i;
  logic [31:0]     instaddr_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic            ex_ready_i;
  logic            valid_o;
  logic [31:0]     inst_o;
  logic [31:0]     instaddr_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            regs_wen_o;
  logic [4:0]      rd_addr_o;
  logic            illegal_o;

  modport slave (
    input  inst_i, instaddr_i, in_valid_i, ex_ready_i,
    output in_ready_o, valid_o, inst_o, instaddr_o, op1_o, op2_o,
           rs1_data_o, rs2_data_o, regs_wen_o, rd_addr_o, illegal_o
  );

  modport master (
    output inst_i, instaddr_i, in_valid_i, ex_ready_i,
    input  in_ready_o, valid_o, inst_o, instaddr_o, op1_o, op2_o,
           rs1_data_o, rs2_data_o, regs_wen_o, rd_addr_o, illegal_o
  );
endinterface

// File: rtl/id_dec.sv
// Combinational RV32I decoder.
// Ports: inst (32-bit instruction) -> dec (operand selects, 32-bit imm,
// register read enables/addresses, rd, write enable, illegal flag).
// Illegal instructions read and write nothing.
module id_dec
  import id_stage_pkg::*;
#(
  parameter int RF_DEPTH = 32
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  localparam logic [5:0] DEPTH = 6'(RF_DEPTH);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_u, imm_sh;
  logic        legal, rs1_rd, rs2_rd, has_rd, bad_idx, ok_rd;
  op1_sel_e    op1_sel;
  op2_sel_e    op2_sel;
  logic [31:0] imm;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  always_comb begin
    legal   = 1'b0;
    rs1_rd  = READ_DISABLE;
    rs2_rd  = READ_DISABLE;
    has_rd  = 1'b0;
    op1_sel = OP1_RS1;
    op2_sel = OP2_ZERO;
    imm     = ZERO_WORD;
    case (opcode)
      OPC_OP_IMM: begin
        rs1_rd  = READ_ENABLE;
        has_rd  = 1'b1;
        op2_sel = OP2_IMM;
        if (funct3 == F3_SLL) begin
          legal = (funct7 == F7_BASE);
          imm   = imm_sh;
        end else if (funct3 == F3_SRL_SRA) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          imm   = imm_sh;
        end else begin
          legal = 1'b1;
          imm   = imm_i;
        end
      end
      OPC_OP: begin
        rs1_rd  = READ_ENABLE;
        rs2_rd  = READ_ENABLE;
        has_rd  = 1'b1;
        op2_sel = OP2_RS2;
        // funct7=0100000 only exists for sub and sra
        legal   = (funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
      end
      OPC_JAL: begin
        legal   = 1'b1;
        has_rd  = 1'b1;
        op1_sel = OP1_PC;
        op2_sel = OP2_FOUR;
      end
      OPC_JALR: begin
        // rs1 is still read: EX needs it for the jump target via rs1_data_o
        legal   = (funct3 == F3_JALR);
        rs1_rd  = READ_ENABLE;
        has_rd  = 1'b1;
        op1_sel = OP1_PC;
        op2_sel = OP2_FOUR;
      end
      OPC_BRANCH: begin
        legal   = (funct3 != F3_SLT) && (funct3 != F3_SLTU);
        rs1_rd  = READ_ENABLE;
        rs2_rd  = READ_ENABLE;
        op2_sel = OP2_RS2;
      end
      OPC_LUI: begin
        legal   = 1'b1;
        has_rd  = 1'b1;
        op1_sel = OP1_IMM;
        op2_sel = OP2_ZERO;
        imm     = imm_u;
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        has_rd  = 1'b1;
        op1_sel = OP1_PC;
        op2_sel = OP2_IMM;
        imm     = imm_u;
      end
      OPC_LOAD: begin
        legal   = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                  (funct3 == F3_LBU) || (funct3 == F3_LHU);
        rs1_rd  = READ_ENABLE;
        has_rd  = 1'b1;
        op2_sel = OP2_IMM;
        imm     = imm_i;
      end
      OPC_STORE: begin
        legal   = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        rs1_rd  = READ_ENABLE;
        rs2_rd  = READ_ENABLE;
        op2_sel = OP2_IMM;
        imm     = imm_s;
      end
      default: legal = 1'b0;
    endcase
  end

  // Only indices the instruction actually uses are range-checked.
  assign bad_idx = (rs1_rd && ({1'b0, rs1} >= DEPTH)) ||
                   (rs2_rd && ({1'b0, rs2} >= DEPTH)) ||
                   (has_rd && ({1'b0, rd}  >= DEPTH));
  assign ok_rd   = has_rd && legal && !bad_idx;

  always_comb begin
    dec          = '0;
    dec.illegal  = !legal || bad_idx;
    dec.op1_sel  = op1_sel;
    dec.op2_sel  = op2_sel;
    dec.imm      = imm;
    dec.rs1_read = rs1_rd && !dec.illegal;
    dec.rs2_read = rs2_rd && !dec.illegal;
    dec.rs1_addr = dec.rs1_read ? rs1 : ZERO_REG;
    dec.rs2_addr = dec.rs2_read ? rs2 : ZERO_REG;
    dec.rd_addr  = ok_rd ? rd : ZERO_REG;
    dec.wen      = (ok_rd && (rd != ZERO_REG)) ? WRITE_ENABLE : WRITE_DISABLE;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode pipeline stage.
// Ports: clk, rstn (async active-low); bus (id_stage_if.slave: issue
// handshake, ex_ready_i and the registered decode bundle); register-file
// read port (rs*_addr_o, rs*_read_o, rs*_data_i); EX/MEM forwarding sources;
// flush_i kills the stage; hold_flag_o requests a load-use stall.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RF_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rstn,
  id_stage_if.slave       bus,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            rs1_read_o,
  output logic            rs2_read_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            ex_wen_i,
  input  logic [4:0]      ex_wr_addr_i,
  input  logic [XLEN-1:0] ex_wr_data_i,
  input  logic            ex_is_load_i,
  input  logic            mem_wen_i,
  input  logic [4:0]      mem_wr_addr_i,
  input  logic [XLEN-1:0] mem_wr_data_i,
  input  logic            flush_i,
  output logic            hold_flag_o
);

  dec_t            dec;
  logic            load_use;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_x, op1, op2;

  id_dec #(.RF_DEPTH(RF_DEPTH)) u_dec (.inst(bus.inst_i), .dec(dec));

  assign rs1_read_o = bus.in_valid_i && dec.rs1_read;
  assign rs2_read_o = bus.in_valid_i && dec.rs2_read;
  assign rs1_addr_o = rs1_read_o ? dec.rs1_addr : ZERO_REG;
  assign rs2_addr_o = rs2_read_o ? dec.rs2_addr : ZERO_REG;

  // Youngest producer wins: EX, then MEM, then the register file.
  function automatic logic [XLEN-1:0] fwd(input logic rd_en, input logic [4:0] addr,
                                          input logic [XLEN-1:0] rf_data);
    if (!rd_en)
      return '0;
    else if (ex_wen_i && (ex_wr_addr_i == addr) && (addr != ZERO_REG))
      return ex_wr_data_i;
    else if (mem_wen_i && (mem_wr_addr_i == addr) && (addr != ZERO_REG))
      return mem_wr_data_i;
    else
      return rf_data;
  endfunction

  assign rs1_val = fwd(rs1_read_o, rs1_addr_o, rs1_data_i);
  assign rs2_val = fwd(rs2_read_o, rs2_addr_o, rs2_data_i);

  // A load in EX has no data yet, so a dependent instruction must wait.
  assign load_use = ex_is_load_i && ex_wen_i && (ex_wr_addr_i != ZERO_REG) &&
                    ((rs1_read_o && (ex_wr_addr_i == rs1_addr_o)) ||
                     (rs2_read_o && (ex_wr_addr_i == rs2_addr_o)));

  assign hold_flag_o    = bus.in_valid_i && load_use && !flush_i;
  assign bus.in_ready_o = bus.ex_ready_i && !hold_flag_o;

  assign imm_x = XLEN'($signed(dec.imm));

  always_comb begin
    op1 = '0;
    case (dec.op1_sel)
      OP1_RS1: op1 = rs1_val;
      OP1_PC:  op1 = XLEN'(bus.instaddr_i);
      OP1_IMM: op1 = imm_x;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (dec.op2_sel)
      OP2_RS2:  op2 = rs2_val;
      OP2_IMM:  op2 = imm_x;
      OP2_FOUR: op2 = XLEN'(4);
      default:  op2 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.valid_o    <= 1'b0;
      bus.inst_o     <= '0;
      bus.instaddr_o <= '0;
      bus.op1_o      <= '0;
      bus.op2_o      <= '0;
      bus.rs1_data_o <= '0;
      bus.rs2_data_o <= '0;
      bus.regs_wen_o <= 1'b0;
      bus.rd_addr_o  <= '0;
      bus.illegal_o  <= 1'b0;
    end else if (flush_i) begin
      bus.valid_o    <= 1'b0;
      bus.regs_wen_o <= 1'b0;
    end else if (!bus.ex_ready_i) begin
      // EX is not taking the current bundle: hold everything
    end else if (hold_flag_o) begin
      bus.valid_o    <= 1'b0;
      bus.regs_wen_o <= 1'b0;
    end else if (bus.in_valid_i) begin
      bus.valid_o    <= 1'b1;
      bus.inst_o     <= bus.inst_i;
      bus.instaddr_o <= bus.instaddr_i;
      bus.op1_o      <= op1;
      bus.op2_o      <= op2;
      bus.rs1_data_o <= rs1_val;
      bus.rs2_data_o <= rs2_val;
      bus.regs_wen_o <= dec.wen;
      bus.rd_addr_o  <= dec.rd_addr;
      bus.illegal_o  <= dec.illegal;
    end else begin
      bus.valid_o    <= 1'b0;
      bus.regs_wen_o <= 1'b0;
    end
  end

endmodule
